// File: rtl/error_monitor_pkg.sv
// error_monitor_pkg: shared definitions for the codeword error monitor.
//   state_t        - measurement FSM encoding (IDLE, RUN, DRAIN, REPORT)
//   DRAIN_CYCLES   - cycles spent flushing the two-stage compare pipeline
//   popcount_width - bits needed to hold a popcount of an n-bit vector
package error_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam int unsigned DRAIN_CYCLES = 2;

    // ceil(log2(n+1)), never less than one bit
    function automatic int unsigned popcount_width(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << w) < (64'(n) + 64'd1)) begin
                w = w + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/error_monitor_popcount.sv
// error_monitor_popcount: combinational population count of a diff vector.
//   diff    - in,  CODEWORD_LENGTH bits, XOR of original and infected codeword
//   count_c - out, popcount_width(CODEWORD_LENGTH) bits, number of set bits
module error_monitor_popcount
    import error_monitor_pkg::*;
#(
    parameter int unsigned CODEWORD_LENGTH = 30,
    localparam int unsigned PC_W = popcount_width(CODEWORD_LENGTH)
) (
    input  logic [CODEWORD_LENGTH-1:0] diff,
    output logic [PC_W-1:0]            count_c
);

    // Straight adder chain; synthesis reshapes it into a tree.
    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(CODEWORD_LENGTH); i++) begin
            count_c = count_c + PC_W'(diff[i]);
        end
    end

endmodule

// File: rtl/error_monitor.sv
// error_monitor: counts sampled codeword pairs, pairs with errors and total
// bit errors between the original and infected codeword lines over a window.
// Optional macro ERROR_MONITOR_SATURATE_EN makes the two error counters
// saturate at all-ones instead of wrapping.
// Ports:
//   i_clk, i_rst_n                  - clock, async active-low reset
//   i_clk_en                        - sample qualifier for the codeword pair
//   i_start, i_window_len           - open a window of i_window_len samples
//   original/infected_codeword_line - codeword before/after error insertion
//   o_busy                          - window running or pipeline draining
//   o_valid, i_ready                - statistics handshake
//   o_word_cnt, o_word_err_cnt, o_bit_err_cnt - statistics counters
module error_monitor
    import error_monitor_pkg::*;
#(
    parameter int unsigned CODEWORD_LENGTH = 30,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clk_en,
    input  logic                       i_start,
    input  logic [CNT_W-1:0]           i_window_len,
    input  logic [CODEWORD_LENGTH-1:0] original_codeword_line,
    input  logic [CODEWORD_LENGTH-1:0] infected_codeword_line,
    output logic                       o_busy,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [CNT_W-1:0]           o_word_cnt,
    output logic [CNT_W-1:0]           o_word_err_cnt,
    output logic [CNT_W-1:0]           o_bit_err_cnt
);

    localparam int unsigned PC_W    = popcount_width(CODEWORD_LENGTH);
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t                     state, next_state;
    logic [CNT_W-1:0]           len_q;
    logic [DRAIN_W-1:0]         drain_cnt;
    logic                       s1_valid;
    logic [CODEWORD_LENGTH-1:0] s1_diff;
    logic                       s2_valid;
    logic [PC_W-1:0]            s2_pc;
    logic [PC_W-1:0]            pc_c;
    logic                       start_c;
    logic                       capture_c;
    logic [CNT_W-1:0]           word_inc_c;
    logic [CNT_W-1:0]           bit_err_next_c;
    logic [CNT_W-1:0]           word_err_next_c;

    error_monitor_popcount #(
        .CODEWORD_LENGTH (CODEWORD_LENGTH)
    ) u_popcount (
        .diff    (s1_diff),
        .count_c (pc_c)
    );

    // Next state and per-cycle strobes
    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        capture_c  = 1'b0;
        word_inc_c = o_word_cnt + CNT_W'(1);
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    start_c    = 1'b1;
                    next_state = (i_window_len == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_clk_en) begin
                    capture_c = 1'b1;
                    if (word_inc_c == len_q) begin
                        next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    next_state = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (i_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Error counter increments, wrapping or saturating
`ifdef ERROR_MONITOR_SATURATE_EN
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    logic [SUM_W-1:0] bit_sum_c;

    always_comb begin
        bit_sum_c       = SUM_W'(o_bit_err_cnt) + SUM_W'(s2_pc);
        bit_err_next_c  = (|bit_sum_c[SUM_W-1:CNT_W]) ? '1 : bit_sum_c[CNT_W-1:0];
        word_err_next_c = (&o_word_err_cnt) ? o_word_err_cnt : o_word_err_cnt + CNT_W'(1);
    end
`else
    always_comb begin
        bit_err_next_c  = o_bit_err_cnt + CNT_W'(s2_pc);
        word_err_next_c = o_word_err_cnt + CNT_W'(1);
    end
`endif

    // State register; busy/valid registered from the next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state     <= next_state;
            o_busy    <= (next_state == ST_RUN) || (next_state == ST_DRAIN);
            o_valid   <= (next_state == ST_REPORT);
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
        end
    end

    // Compare pipeline (capture -> popcount -> accumulate) and counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q          <= '0;
            s1_valid       <= 1'b0;
            s1_diff        <= '0;
            s2_valid       <= 1'b0;
            s2_pc          <= '0;
            o_word_cnt     <= '0;
            o_word_err_cnt <= '0;
            o_bit_err_cnt  <= '0;
        end else begin
            s1_valid <= capture_c;
            s1_diff  <= capture_c ? (original_codeword_line ^ infected_codeword_line) : '0;
            s2_valid <= s1_valid;
            s2_pc    <= s1_valid ? pc_c : '0;
            if (start_c) begin
                len_q          <= i_window_len;
                o_word_cnt     <= '0;
                o_word_err_cnt <= '0;
                o_bit_err_cnt  <= '0;
            end else begin
                if (capture_c) begin
                    o_word_cnt <= word_inc_c;
                end
                if (s2_valid) begin
                    o_bit_err_cnt <= bit_err_next_c;
                    if (s2_pc != '0) begin
                        o_word_err_cnt <= word_err_next_c;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_error_monitor.sv
// tb_error_monitor: self-checking bench for error_monitor. A vector table of
// windows (directed and random) is replayed against a reference model that
// counts sampled pairs and differing bits directly; hand-written sequences
// cover mid-window reset and a narrow-counter instance (CNT_W=4).
module tb_error_monitor;

    localparam int unsigned CW   = 30;
    localparam int unsigned CNT  = 32;
    localparam int unsigned CNT4 = 4;

    localparam int M_RANDOM = 0;
    localparam int M_STUCK  = 1;
    localparam int M_CLEAN  = 2;
    localparam int M_ALT3   = 3;
    localparam int M_DENSE  = 4;

    localparam logic [CW-1:0] ALT_MASK = 30'h2000_8001;

`ifdef ERROR_MONITOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int              len;
        int              mode;
        int              hold;
        bit              has_exp;
        longint unsigned ew;
        longint unsigned ewe;
        longint unsigned ebe;
        int              lat;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            clk_en = 1'b0;
    logic            start = 1'b0;
    logic            ready = 1'b0;
    logic [CNT-1:0]  win_len = '0;
    logic [CW-1:0]   orig = '0;
    logic [CW-1:0]   inf = '0;
    logic            busy, valid;
    logic [CNT-1:0]  wc, wec, bec;

    logic            start4 = 1'b0;
    logic            ready4 = 1'b0;
    logic [CNT4-1:0] win_len4 = '0;
    logic            busy4, valid4;
    logic [CNT4-1:0] wc4, wec4, bec4;

    int total = 0;
    int bad   = 0;

    error_monitor #(.CODEWORD_LENGTH(CW), .CNT_W(CNT)) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_clk_en               (clk_en),
        .i_start                (start),
        .i_window_len           (win_len),
        .original_codeword_line (orig),
        .infected_codeword_line (inf),
        .o_busy                 (busy),
        .o_valid                (valid),
        .i_ready                (ready),
        .o_word_cnt             (wc),
        .o_word_err_cnt         (wec),
        .o_bit_err_cnt          (bec)
    );

    error_monitor #(.CODEWORD_LENGTH(CW), .CNT_W(CNT4)) dut4 (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_clk_en               (clk_en),
        .i_start                (start4),
        .i_window_len           (win_len4),
        .original_codeword_line (orig),
        .infected_codeword_line (inf),
        .o_busy                 (busy4),
        .o_valid                (valid4),
        .i_ready                (ready4),
        .o_word_cnt             (wc4),
        .o_word_err_cnt         (wec4),
        .o_bit_err_cnt          (bec4)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Drive one codeword pair and its qualifier for the coming edge
    task automatic drive_pair(input int mode, input int phase);
        logic [CW-1:0] o, m;
        o = CW'($urandom);
        case (mode)
            M_STUCK: begin o = '0; m = CW'(1) << 28; clk_en = 1'b1; end
            M_CLEAN: begin m = '0; clk_en = 1'b1; end
            M_ALT3:  begin m = ALT_MASK; clk_en = (phase % 2 == 0); end
            M_DENSE: begin m = CW'($urandom); clk_en = 1'($urandom_range(0, 1)); end
            default: begin
                m = CW'($urandom & $urandom & $urandom);
                if ($urandom_range(0, 3) == 0) m = '0;
                clk_en = 1'($urandom_range(0, 1));
            end
        endcase
        orig = o;
        inf  = o ^ m;
    endtask

    // One full window: start, sample, drain, report hold, handshake
    task automatic run_window(input vec_t v, input string nm);
        longint unsigned mw, mwe, mbe, ew, ewe, ebe, msk;
        int              edge_n, last, consumed, phase;
        logic [CW-1:0]   d;
        mw = 0; mwe = 0; mbe = 0; consumed = 0; phase = 0;
        msk = (longint'(1) << CNT) - 1;

        win_len = CNT'(v.len);
        start   = 1'b1;
        drive_pair(v.mode, 1);
        @(posedge clk); #1;
        start   = 1'b0;
        win_len = CNT'($urandom);
        edge_n  = 1;
        last    = 1;
        check({nm, "/busy_start"}, busy, 1);

        while (consumed < v.len) begin
            drive_pair(v.mode, phase);
            phase++;
            @(posedge clk);
            edge_n++;
            if (clk_en) begin
                consumed++;
                d = orig ^ inf;
                mw++;
                if (d != '0) mwe++;
                mbe += longint'($countones(d));
                last = edge_n;
            end
            #1;
        end

        while (!valid && edge_n < last + 10) begin
            drive_pair(M_DENSE, 0);
            @(posedge clk); #1;
            edge_n++;
        end
        check({nm, "/valid_edge"}, longint'(edge_n), longint'(last + 2));
        if (v.lat != 0) check({nm, "/latency"}, longint'(edge_n), longint'(v.lat));

        ew  = v.has_exp ? v.ew  : (mw  & msk);
        ewe = v.has_exp ? v.ewe : (mwe & msk);
        ebe = v.has_exp ? v.ebe : (mbe & msk);
        check({nm, "/valid"}, valid, 1);
        check({nm, "/busy_rep"}, busy, 0);
        check({nm, "/word"}, wc, ew);
        check({nm, "/word_err"}, wec, ewe);
        check({nm, "/bit_err"}, bec, ebe);

        for (int i = 0; i < v.hold; i++) begin
            drive_pair(M_DENSE, 0);
            start   = (i == 1);
            win_len = 32'd5;
            @(posedge clk); #1;
            start = 1'b0;
            check({nm, "/hold_valid"}, valid, 1);
            check({nm, "/hold_busy"}, busy, 0);
            check({nm, "/hold_bit_err"}, bec, ebe);
            check({nm, "/hold_word"}, wc, ew);
        end

        ready   = 1'b1;
        start   = 1'b1;
        win_len = 32'd3;
        @(posedge clk); #1;
        ready = 1'b0;
        start = 1'b0;
        check({nm, "/hs_valid"}, valid, 0);
        check({nm, "/hs_busy"}, busy, 0);
        @(posedge clk); #1;
        check({nm, "/idle_busy"}, busy, 0);
        check({nm, "/keep_word_err"}, wec, ewe);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{len: 10,   mode: M_STUCK,  hold: 0,  has_exp: 1, ew: 10,   ewe: 10, ebe: 10, lat: 13};
        vecs[1] = '{len: 1000, mode: M_CLEAN,  hold: 0,  has_exp: 1, ew: 1000, ewe: 0,  ebe: 0,  lat: 1003};
        vecs[2] = '{len: 4,    mode: M_ALT3,   hold: 0,  has_exp: 1, ew: 4,    ewe: 4,  ebe: 12, lat: 10};
        vecs[3] = '{len: 0,    mode: M_RANDOM, hold: 20, has_exp: 1, ew: 0,    ewe: 0,  ebe: 0,  lat: 3};
        vecs[4] = '{len: 1,    mode: M_RANDOM, hold: 3,  has_exp: 0, ew: 0,    ewe: 0,  ebe: 0,  lat: 0};
        vecs[5] = '{len: 17,   mode: M_RANDOM, hold: 0,  has_exp: 0, ew: 0,    ewe: 0,  ebe: 0,  lat: 0};
        vecs[6] = '{len: 33,   mode: M_DENSE,  hold: 2,  has_exp: 0, ew: 0,    ewe: 0,  ebe: 0,  lat: 0};
        vecs[7] = '{len: 25,   mode: M_RANDOM, hold: 0,  has_exp: 0, ew: 0,    ewe: 0,  ebe: 0,  lat: 0};

        #2 rst_n = 1'b0;
        #20;
        check("reset/busy", busy, 0);
        check("reset/valid", valid, 0);
        check("reset/word", wc, 0);
        check("reset/word_err", wec, 0);
        check("reset/bit_err", bec, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a running window
        drive_pair(M_STUCK, 0);
        win_len = 32'd20;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst/pre_word", wc, 5);
        check("midrst/pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst/busy", busy, 0);
        check("midrst/valid", valid, 0);
        check("midrst/word", wc, 0);
        check("midrst/word_err", wec, 0);
        check("midrst/bit_err", bec, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst/no_autostart", busy, 0);
        end
        run_window('{len: 2, mode: M_STUCK, hold: 0, has_exp: 1, ew: 2, ewe: 2, ebe: 2, lat: 5}, "after_rst");

        // Narrow counters: 3 errored bits x 8 words overflows 4 bits
        orig     = '0;
        inf      = ALT_MASK;
        clk_en   = 1'b1;
        win_len4 = 4'd8;
        start4   = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 0; i < 30 && !valid4; i++) begin
            @(posedge clk); #1;
        end
        check("cnt4/valid", valid4, 1);
        check("cnt4/word", wc4, 8);
        check("cnt4/word_err", wec4, 8);
        check("cnt4/bit_err", bec4, SAT ? 15 : 8);
        ready4 = 1'b1;
        @(posedge clk); #1;
        ready4 = 1'b0;
        check("cnt4/hs_valid", valid4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/error_monitor.md
ERROR_MONITOR -- requirements
Module: error_monitor

Interface
REQ-001 SHALL have parameter CODEWORD_LENGTH, default 30, width of both codeword lines (1..31).
REQ-002 SHALL have parameter CNT_W, default 32, width of every statistics counter and of i_window_len.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_clk_en  input  1  sample qualifier; a codeword pair is consumed only when high.
REQ-007 i_start  input  1  one-cycle pulse that opens a measurement window.
REQ-008 i_window_len  input  CNT_W  number of qualified codeword pairs per window; latched on accepted i_start.
REQ-009 original_codeword_line  input  CODEWORD_LENGTH  codeword before the error-insertion stage.
REQ-010 infected_codeword_line  input  CODEWORD_LENGTH  same codeword after the error-insertion stage, time-aligned by the integrator.
REQ-011 o_busy  output  1  high in RUN and DRAIN.
REQ-012 o_valid  output  1  statistics valid; high only in REPORT.
REQ-013 i_ready  input  1  consumer accepts statistics.
REQ-014 o_word_cnt / o_word_err_cnt / o_bit_err_cnt  output  CNT_W each  pairs sampled / pairs with at least one differing bit / total differing bits.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, REPORT.
REQ-016 IDLE->RUN on i_start; all counters cleared and i_window_len latched on the same edge; i_start outside IDLE SHALL be ignored.
REQ-017 i_start with latched length 0 SHALL go IDLE->DRAIN directly, reporting all-zero counts.
REQ-018 In RUN, each cycle with i_clk_en high SHALL capture diff = original XOR infected into stage-1 register with a valid bit; o_word_cnt increments on that edge.
REQ-019 Stage 2 SHALL popcount the stage-1 diff (ceil(log2(CODEWORD_LENGTH+1)) bits, zero-extended to CNT_W) and add it to o_bit_err_cnt; o_word_err_cnt increments when popcount is non-zero.
REQ-020 Pipeline SHALL advance every cycle independent of i_clk_en; an input pair affects the error counters exactly 2 cycles after capture.
REQ-021 RUN->DRAIN on the edge capturing the sample that makes o_word_cnt equal the latched length; no further samples are taken.
REQ-022 DRAIN SHALL last exactly 2 cycles, then go to REPORT.
REQ-023 In REPORT, o_valid high and all counters held stable until o_valid && i_ready; then REPORT->IDLE, counters retained until next start.
REQ-024 i_start coincident with the REPORT handshake SHALL be ignored.
REQ-025 Counter arithmetic SHALL be unsigned modulo 2^CNT_W unless REQ-030 applies.

Reset
REQ-026 Reset assertion SHALL immediately force IDLE, clear pipeline valids and registers, and zero all outputs, including mid-RUN/DRAIN/REPORT.
REQ-027 First state change after deassertion SHALL require a new i_start.

Configuration
REQ-028 Macro ERROR_MONITOR_SATURATE_EN SHALL select counter overflow behaviour.
REQ-029 Without it, counters wrap modulo 2^CNT_W.
REQ-030 With it, o_bit_err_cnt and o_word_err_cnt SHALL saturate at 2^CNT_W-1; o_word_cnt is unaffected (bounded by the window).

Structure
REQ-031 Package error_monitor_pkg SHALL hold the FSM state encoding, DRAIN_CYCLES=2 and the popcount-width function.
REQ-032 Sub-module error_monitor_popcount (parameter CODEWORD_LENGTH, combinational) SHALL perform the bit count.

Verification
REQ-033 Stuck-at bit 28: original=0, infected=1<<28, window 10, clk_en=1 -> word 10, word_err 10, bit_err 10; o_valid 13 cycles after start.
REQ-034 Clean line: infected==original, window 1000 -> word 1000, word_err 0, bit_err 0.
REQ-035 3 differing bits per word, window 4, clk_en alternating 1/0 -> word 4, word_err 4, bit_err 12; only enabled cycles sampled.
REQ-036 Reset asserted mid-RUN after 5 samples -> outputs 0, IDLE; new start window 2 -> word 2.
REQ-037 CNT_W=4, 3 bits per word, window 8 -> bit_err 15 with ERROR_MONITOR_SATURATE_EN, 8 without.
REQ-038 Window 0 -> o_valid with all-zero counts; i_ready held low 20 cycles -> counts stable, o_valid held; start during REPORT ignored.
